// File: rtl/retire_unit_nw_if.sv
// ROB-head window into the retire unit plus its retirement outputs; the
// perf counters appear only when RETIRE_PERF_EN is defined.
interface retire_unit_nw_if #(
  parameter int RETIRE_WIDTH = 3,
  parameter int XLEN         = 32,
  parameter int PREG_W       = 6,
  parameter int CNT_W        = 64
);
  logic [RETIRE_WIDTH-1:0]        head_valid;
  logic [RETIRE_WIDTH-1:0]        head_completed;
  logic [RETIRE_WIDTH-1:0]        head_precise;
  logic [RETIRE_WIDTH-1:0]        head_is_store;
  logic [RETIRE_WIDTH-1:0]        head_halt;
  logic [RETIRE_WIDTH-1:0]        head_has_dest;
  logic [RETIRE_WIDTH*XLEN-1:0]   head_pc;
  logic [RETIRE_WIDTH*5-1:0]      head_arch_reg;
  logic [RETIRE_WIDTH*PREG_W-1:0] head_phys_reg;

  logic [RETIRE_WIDTH-1:0]        retire_en_mask;
  logic [RETIRE_WIDTH-1:0]        sq_retire_mask;
  logic                           fch_rec_enable;
  logic [XLEN-1:0]                rec_pc;
  logic [32*PREG_W-1:0]           recover_maptable;
  logic                           halt;
  logic [CNT_W-1:0]               retired_inst_cnt;
`ifdef RETIRE_PERF_EN
  logic [31:0]                    mispredict_cnt;
  logic [31:0]                    stall_cycle_cnt;
`endif

  modport master (
`ifdef RETIRE_PERF_EN
    input  mispredict_cnt, stall_cycle_cnt,
`endif
    output head_valid, head_completed, head_precise, head_is_store, head_halt,
    output head_has_dest, head_pc, head_arch_reg, head_phys_reg,
    input  retire_en_mask, sq_retire_mask, fch_rec_enable, rec_pc,
    input  recover_maptable, halt, retired_inst_cnt
  );

  modport slave (
`ifdef RETIRE_PERF_EN
    output mispredict_cnt, stall_cycle_cnt,
`endif
    input  head_valid, head_completed, head_precise, head_is_store, head_halt,
    input  head_has_dest, head_pc, head_arch_reg, head_phys_reg,
    output retire_en_mask, sq_retire_mask, fch_rec_enable, rec_pc,
    output recover_maptable, halt, retired_inst_cnt
  );
endinterface

// File: rtl/retire_unit_nw.sv
// N-wide in-order retire: combinational retire masks, map/counter/recovery update on the next edge.
// No backpressure: retirement simply stalls during FLUSH and HALTED. Optional RETIRE_PERF_EN adds perf counters.
module retire_unit_nw #(
  parameter int RETIRE_WIDTH = 3,
  parameter int ST_PER_CYCLE = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int XLEN         = 32,
  parameter int PREG_W       = 6,
  parameter int CNT_W        = 64
) (
  input logic             clock,
  input logic             reset,
  retire_unit_nw_if.slave bus
);
  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;

  state_t                   state, state_nxt;
  logic [FC_W-1:0]          flush_cnt;
  logic [RETIRE_WIDTH-1:0]  ret_mask, st_mask;
  logic                     hit_prec, hit_halt;
  logic [XLEN-1:0]          hit_pc;
  logic [31:0][PREG_W-1:0]  map;
  logic [CNT_W-1:0]         cnt;
  logic                     rec_en;
  logic [XLEN-1:0]          rec_pc_q;
  logic                     halt_q;

  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (hit_halt)      state_nxt = HALTED;
        else if (hit_prec) state_nxt = FLUSH;
      end
      FLUSH:   if (flush_cnt <= FC_W'(1)) state_nxt = RUN;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  // Walk oldest (MSB) to youngest; the first non-retiring slot blocks all younger ones.
  always_comb begin
    int   n_st;
    logic stop;
    ret_mask = '0;
    st_mask  = '0;
    hit_prec = 1'b0;
    hit_halt = 1'b0;
    hit_pc   = '0;
    n_st     = 0;
    stop     = 1'b0;
    if (!reset && state == RUN) begin
      for (int i = RETIRE_WIDTH - 1; i >= 0; i--) begin
        if (!stop) begin
          if (!(bus.head_valid[i] && bus.head_completed[i])) begin
            stop = 1'b1;
          end else if (bus.head_is_store[i] && n_st >= ST_PER_CYCLE) begin
            stop = 1'b1;
          end else begin
            ret_mask[i] = 1'b1;
            if (bus.head_is_store[i]) begin
              st_mask[i] = 1'b1;
              n_st       = n_st + 1;
            end
            if (bus.head_halt[i]) begin
              hit_halt = 1'b1;
              stop     = 1'b1;
            end else if (bus.head_precise[i]) begin
              hit_prec = 1'b1;
              hit_pc   = bus.head_pc[i*XLEN +: XLEN];
              stop     = 1'b1;
            end
          end
        end
      end
    end
  end

  // Map writes issue oldest first so the youngest writer of an arch reg lands last.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) map[i] <= PREG_W'(i);
      cnt       <= '0;
      rec_en    <= 1'b0;
      rec_pc_q  <= '0;
      halt_q    <= 1'b0;
      flush_cnt <= '0;
    end else begin
      for (int i = RETIRE_WIDTH - 1; i >= 0; i--) begin
        if (ret_mask[i] && bus.head_has_dest[i] && bus.head_arch_reg[i*5 +: 5] != 5'd0)
          map[bus.head_arch_reg[i*5 +: 5]] <= bus.head_phys_reg[i*PREG_W +: PREG_W];
      end
      cnt    <= cnt + CNT_W'($countones(ret_mask));
      rec_en <= hit_prec;
      if (hit_prec) rec_pc_q <= hit_pc;
      halt_q <= halt_q | hit_halt;
      if (hit_prec)
        flush_cnt <= FC_W'(FLUSH_CYCLES);
      else if (state == FLUSH && flush_cnt != '0)
        flush_cnt <= flush_cnt - FC_W'(1);
    end
  end

  assign bus.retire_en_mask   = ret_mask;
  assign bus.sq_retire_mask   = st_mask;
  assign bus.fch_rec_enable   = rec_en;
  assign bus.rec_pc           = rec_pc_q;
  assign bus.recover_maptable = map;
  assign bus.halt             = halt_q;
  assign bus.retired_inst_cnt = cnt;

`ifdef RETIRE_PERF_EN
  logic [31:0] mis_cnt, stall_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      mis_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (hit_prec) mis_cnt <= mis_cnt + 32'd1;
      if (state == RUN && bus.head_valid[RETIRE_WIDTH-1] && !bus.head_completed[RETIRE_WIDTH-1])
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.mispredict_cnt  = mis_cnt;
  assign bus.stall_cycle_cnt = stall_cnt;
`endif
endmodule

// File: tb/tb_retire_unit_nw.sv
// Self-checking bench for retire_unit_nw: directed test-plan cases plus random traffic against a behavioural model.
module tb_retire_unit_nw;
  localparam int W            = 3;
  localparam int XLEN         = 32;
  localparam int PREG_W       = 6;
  localparam int CNT_W        = 64;
  localparam int ST_PER_CYCLE = 1;
  localparam int FLUSH_CYCLES = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  retire_unit_nw_if #(.RETIRE_WIDTH(W), .XLEN(XLEN), .PREG_W(PREG_W), .CNT_W(CNT_W)) bus ();

  retire_unit_nw #(
    .RETIRE_WIDTH(W), .ST_PER_CYCLE(ST_PER_CYCLE), .FLUSH_CYCLES(FLUSH_CYCLES),
    .XLEN(XLEN), .PREG_W(PREG_W), .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  logic [W-1:0]      t_valid, t_comp, t_prec, t_store, t_halt, t_dest;
  logic [XLEN-1:0]   t_pc   [W];
  logic [4:0]        t_arch [W];
  logic [PREG_W-1:0] t_phys [W];

  assign bus.head_valid     = t_valid;
  assign bus.head_completed = t_comp;
  assign bus.head_precise   = t_prec;
  assign bus.head_is_store  = t_store;
  assign bus.head_halt      = t_halt;
  assign bus.head_has_dest  = t_dest;
  for (genvar s = 0; s < W; s++) begin : g_pack
    assign bus.head_pc[s*XLEN +: XLEN]         = t_pc[s];
    assign bus.head_arch_reg[s*5 +: 5]         = t_arch[s];
    assign bus.head_phys_reg[s*PREG_W +: PREG_W] = t_phys[s];
  end

  // Behavioural model state
  logic [PREG_W-1:0] m_map [32];
  logic [63:0]       m_cnt;
  bit                m_halted;
  int                m_flush_left;
  bit                m_rec_en;
  logic [XLEN-1:0]   m_rec_pc;
  int unsigned       m_mispred, m_stall;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_map[i] = PREG_W'(i);
    m_cnt = '0; m_halted = 0; m_flush_left = 0; m_rec_en = 0; m_rec_pc = '0;
    m_mispred = 0; m_stall = 0;
  endtask

  // Longest eligible prefix from the oldest slot, cut by the store budget and by precise/halt.
  function automatic void model_select(output logic [W-1:0] m, output logic [W-1:0] sq);
    int stores = 0;
    m = '0; sq = '0;
    if (m_halted || m_flush_left > 0) return;
    for (int s = W - 1; s >= 0; s--) begin
      if (!(t_valid[s] && t_comp[s])) break;
      if (t_store[s]) begin
        if (stores == ST_PER_CYCLE) break;
        stores++;
        sq[s] = 1'b1;
      end
      m[s] = 1'b1;
      if (t_halt[s] || t_prec[s]) break;
    end
  endfunction

  task automatic model_edge(input logic [W-1:0] m);
    int youngest = -1;
    bit in_run   = !m_halted && m_flush_left == 0;
    if (in_run && t_valid[W-1] && !t_comp[W-1]) m_stall++;
    m_rec_en = 0;
    for (int s = W - 1; s >= 0; s--) begin
      if (m[s]) begin
        youngest = s;
        if (t_dest[s] && t_arch[s] != 0) m_map[t_arch[s]] = t_phys[s];
      end
    end
    m_cnt = m_cnt + 64'($countones(m));
    if (m_flush_left > 0) m_flush_left--;
    if (youngest >= 0) begin
      if (t_halt[youngest]) m_halted = 1;
      else if (t_prec[youngest]) begin
        m_rec_en = 1; m_rec_pc = t_pc[youngest];
        m_flush_left = FLUSH_CYCLES; m_mispred++;
      end
    end
  endtask

  task automatic step();
    logic [W-1:0] m, sq;
    #1;
    model_select(m, sq);
    chk("retire_en_mask", 64'(bus.retire_en_mask), 64'(m));
    chk("sq_retire_mask", 64'(bus.sq_retire_mask), 64'(sq));
    chk("fch_rec_enable", 64'(bus.fch_rec_enable), 64'(m_rec_en));
    chk("rec_pc", 64'(bus.rec_pc), 64'(m_rec_pc));
    chk("halt", 64'(bus.halt), 64'(m_halted));
    chk("retired_inst_cnt", bus.retired_inst_cnt, m_cnt);
    for (int i = 0; i < 32; i++)
      chk($sformatf("map[%0d]", i), 64'(bus.recover_maptable[i*PREG_W +: PREG_W]), 64'(m_map[i]));
`ifdef RETIRE_PERF_EN
    chk("mispredict_cnt", 64'(bus.mispredict_cnt), 64'(m_mispred));
    chk("stall_cycle_cnt", 64'(bus.stall_cycle_cnt), 64'(m_stall));
`endif
    @(posedge clock);
    model_edge(m);
    #1;
  endtask

  task automatic clear_slots();
    t_valid = '0; t_comp = '0; t_prec = '0; t_store = '0; t_halt = '0; t_dest = '0;
    for (int s = 0; s < W; s++) begin
      t_pc[s] = '0; t_arch[s] = '0; t_phys[s] = '0;
    end
  endtask

  task automatic rand_inputs();
    for (int s = 0; s < W; s++) begin
      t_valid[s] = ($urandom_range(9) != 0);
      t_comp[s]  = ($urandom_range(4) != 0);
      t_prec[s]  = ($urandom_range(9) == 0);
      t_store[s] = ($urandom_range(2) == 0);
      t_halt[s]  = ($urandom_range(59) == 0);
      t_dest[s]  = 1'($urandom_range(1));
      t_arch[s]  = ($urandom_range(3) == 0) ? 5'($urandom) : 5'($urandom_range(7));
      t_phys[s]  = PREG_W'($urandom);
      t_pc[s]    = $urandom;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rand_inputs();
    #1 chk("mask_in_reset", 64'(bus.retire_en_mask), 64'(0));
    @(posedge clock);
    model_reset();
    #1 reset = 1'b0;
  endtask

  initial begin
    clear_slots();
    do_reset();

    // All three retire, distinct destinations
    clear_slots();
    t_valid = 3'b111; t_comp = 3'b111; t_dest = 3'b111;
    t_arch[2] = 5'd1; t_phys[2] = 6'd40;
    t_arch[1] = 5'd2; t_phys[1] = 6'd41;
    t_arch[0] = 5'd3; t_phys[0] = 6'd42;
    #1 chk("tp_all3_mask", 64'(bus.retire_en_mask), 64'h7);
    step();
    chk("tp_map1", 64'(bus.recover_maptable[1*PREG_W +: PREG_W]), 64'd40);
    chk("tp_map3", 64'(bus.recover_maptable[3*PREG_W +: PREG_W]), 64'd42);
    chk("tp_cnt3", bus.retired_inst_cnt, 64'd3);

    // Incomplete middle slot blocks younger
    clear_slots();
    t_valid = 3'b111; t_comp = 3'b101;
    #1 chk("tp_gap_mask", 64'(bus.retire_en_mask), 64'h4);
    step();
    chk("tp_gap_cnt", bus.retired_inst_cnt, 64'd4);

    // Precise retire launches recovery and a two-cycle flush
    clear_slots();
    t_valid = 3'b110; t_comp = 3'b110; t_prec = 3'b100; t_pc[2] = 32'h8000_0000;
    #1 chk("tp_prec_mask", 64'(bus.retire_en_mask), 64'h4);
    step();
    chk("tp_rec_pulse", 64'(bus.fch_rec_enable), 64'd1);
    chk("tp_rec_pc", 64'(bus.rec_pc), 64'h8000_0000);
    clear_slots();
    t_valid = 3'b111; t_comp = 3'b111; t_prec = 3'b111;
    #1 chk("tp_flush_mask0", 64'(bus.retire_en_mask), 64'h0);
    step();
    chk("tp_pulse_once", 64'(bus.fch_rec_enable), 64'd0);
    #1 chk("tp_flush_mask1", 64'(bus.retire_en_mask), 64'h0);
    step();
    t_prec = 3'b000;
    #1 chk("tp_run_resume", 64'(bus.retire_en_mask), 64'h7);
    step();

    // Store budget of one
    clear_slots();
    t_valid = 3'b111; t_comp = 3'b111; t_store = 3'b110;
    #1 chk("tp_st_mask", 64'(bus.retire_en_mask), 64'h4);
    chk("tp_st_sq", 64'(bus.sq_retire_mask), 64'h4);
    step();

    // Same arch reg written twice: youngest wins
    clear_slots();
    t_valid = 3'b111; t_comp = 3'b111; t_dest = 3'b101;
    t_arch[2] = 5'd5; t_phys[2] = 6'd10;
    t_arch[0] = 5'd5; t_phys[0] = 6'd12;
    step();
    chk("tp_map5_young", 64'(bus.recover_maptable[5*PREG_W +: PREG_W]), 64'd12);

    // Halt is absorbing until reset
    clear_slots();
    t_valid = 3'b111; t_comp = 3'b111; t_halt = 3'b010; t_prec = 3'b010;
    #1 chk("tp_halt_mask", 64'(bus.retire_en_mask), 64'h6);
    step();
    chk("tp_halt_set", 64'(bus.halt), 64'd1);
    chk("tp_halt_nopulse", 64'(bus.fch_rec_enable), 64'd0);
    for (int k = 0; k < 8; k++) begin
      rand_inputs();
      t_valid = 3'b111; t_comp = 3'b111;
      #1 chk("tp_halted_mask", 64'(bus.retire_en_mask), 64'h0);
      step();
    end
    do_reset();
    chk("tp_halt_cleared", 64'(bus.halt), 64'd0);

    // Reset mid-flush drops the pending pulse
    clear_slots();
    t_valid = 3'b100; t_comp = 3'b100; t_prec = 3'b100; t_pc[2] = 32'h1234_5678;
    step();
    chk("tp_pulse_before_rst", 64'(bus.fch_rec_enable), 64'd1);
    do_reset();
    chk("tp_pulse_dropped", 64'(bus.fch_rec_enable), 64'd0);
    chk("tp_rec_pc_rst", 64'(bus.rec_pc), 64'd0);
    clear_slots();
    t_valid = 3'b111; t_comp = 3'b111;
    #1 chk("tp_run_after_rst", 64'(bus.retire_en_mask), 64'h7);
    step();

    // Random traffic
    for (int c = 0; c < 1200; c++) begin
      if ($urandom_range(149) == 0) do_reset();
      rand_inputs();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/retire_unit_nw.md
Name: retire_unit_nw

Overview:
- Parametrised N-wide in-order retire unit between the ROB head and the free list, store queue, fetch redirect and architectural map.
- Picks the retirable prefix of the ROB head window and commits it to an internal retirement map table.
- On a precise-state (mispredict) retire, launches a registered fetch recovery and holds a FLUSH window.
- Latches halt and counts retired instructions.

Parameters:
- RETIRE_WIDTH, 3, ROB head slots examined per cycle; slot RETIRE_WIDTH-1 is oldest.
- ST_PER_CYCLE, 1, max stores retired per cycle.
- FLUSH_CYCLES, 2, cycles retirement is blocked after a recovery is launched (>=1).
- XLEN, 32, PC width.
- PREG_W, 6, physical register tag width.
- CNT_W, 64, retired-instruction counter width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- head_valid  in  RETIRE_WIDTH  slot holds a live ROB entry.
- head_completed  in  RETIRE_WIDTH  entry finished execution.
- head_precise  in  RETIRE_WIDTH  entry requires precise-state recovery (mispredict).
- head_is_store  in  RETIRE_WIDTH  entry is a store.
- head_halt  in  RETIRE_WIDTH  entry is a halt instruction.
- head_has_dest  in  RETIRE_WIDTH  entry writes an architectural register (arch reg 0 never counts).
- head_pc  in  RETIRE_WIDTH*XLEN  recovery target PC per slot.
- head_arch_reg  in  RETIRE_WIDTH*5  destination architectural register.
- head_phys_reg  in  RETIRE_WIDTH*PREG_W  destination physical tag.
- retire_en_mask  out  RETIRE_WIDTH  combinational; slots retiring this cycle.
- sq_retire_mask  out  RETIRE_WIDTH  combinational; retiring stores.
- fch_rec_enable  out  1  registered one-cycle recovery pulse.
- rec_pc  out  XLEN  registered recovery PC; valid with fch_rec_enable.
- recover_maptable  out  32*PREG_W  registered retirement map table.
- halt  out  1  registered, sticky.
- retired_inst_cnt  out  CNT_W  registered count of retired instructions.

Behaviour:
- FSM states RUN, FLUSH, HALTED. Reset → RUN.
- Reset values:
  - masks 0
  - fch_rec_enable 0
  - rec_pc 0
  - halt 0
  - retired_inst_cnt 0
  - recover_maptable entry i = i (zero-extended)
  - flush counter 0
- Retire selection in RUN, walking from oldest slot down:
  - A slot retires only if valid, completed, and every older slot retires.
  - A store that would exceed ST_PER_CYCLE stops the walk; it does not retire.
  - A retiring slot with head_precise or head_halt retires itself, then no younger slot retires.
- Masks are all zero in FLUSH and HALTED.
- Map update (next edge):
  - For each retiring slot with has_dest and arch_reg != 0, in oldest-to-youngest order: map[arch] ← phys.
  - Multiple writes to the same arch reg in one cycle → youngest wins.
- Counter: retired_inst_cnt += popcount(retire_en_mask); wraps modulo 2^CNT_W.
- Precise retire:
  - Next edge: fch_rec_enable = 1 for exactly one cycle, rec_pc = that slot's head_pc, state → FLUSH.
  - Flush counter loads FLUSH_CYCLES; state returns to RUN when it reaches 0, decrementing once per cycle in FLUSH.
  - A second precise entry cannot retire during FLUSH.
- Halt retire: next edge halt = 1 and state → HALTED; absorbing until reset.
  - Halt and precise in the same retiring slot: halt wins; no recovery pulse.
- No valid entries or oldest slot not completed: masks 0, state unchanged.
- Reset asserted mid-FLUSH or in HALTED: all state returns to reset values on that edge; the pending pulse is dropped.

Optional Feature:
- Macro RETIRE_PERF_EN.
- Defined: adds outputs mispredict_cnt (32b) and stall_cycle_cnt (32b), both reset to 0.
  - mispredict_cnt increments once per launched recovery.
  - stall_cycle_cnt increments each RUN cycle where the oldest slot is valid but not completed.
  - Both wrap.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- After reset, all 3 slots valid and completed, no stores, dests (arch 1,2,3 → phys 40,41,42) → retire_en_mask=3'b111; next cycle map[1..3]=40,41,42, retired_inst_cnt=3.
- Slot 2 completed, slot 1 not completed, slot 0 completed → mask=3'b100; cnt +1.
- Slot 2 completed, precise, pc=32'h80000000; slot 1 completed → mask=3'b100; next cycle fch_rec_enable=1, rec_pc=32'h80000000; masks 0 for 2 cycles; fch_rec_enable=0 after one cycle; RUN resumes.
- Slots 2 and 1 both completed stores, ST_PER_CYCLE=1 → mask=3'b100, sq_retire_mask=3'b100.
- Slot 1 halt, completed, slot 2 completed → mask=3'b110; halt=1 next cycle; all later masks 0 with any stimulus; reset clears halt.
- Slots 2 and 0 both retire writing arch 5 (phys 10, 12) → map[5]=12.
